// File: rtl/serial_tx_param.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_param
//  Purpose  : Parametrised serial transmitter. Takes a parallel word over a
//             Valid/Ready handshake and sends it as a frame:
//             start bit (1), DATA_W data bits, optional parity bit, then
//             STOP_BITS stop bits (0). Each bit lasts DIV clocks. A bit clock
//             for the receiver is produced alongside the data.
//  Ports    : Clk       - system clock, all logic on posedge
//             Reset     - synchronous active-high reset
//             PDin      - parallel word, sampled only on the accept cycle
//             Valid     - producer has a word on PDin
//             Ready     - transmitter can accept (transfer = Valid && Ready)
//             SDout     - serial data, idle level 0
//             SDClk     - bit clock, 0 in idle, rises mid-bit
//             Busy      - high while a frame is on the line
//             FrameDone - one-cycle pulse after the last stop bit
//  Revision : 1.0  initial release
// ============================================================================
module serial_tx_param #(
  parameter int DATA_W     = 8,
  parameter int DIV        = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] PDin,
  input  logic              Valid,
  output logic              Ready,
  output logic              SDout,
  output logic              SDClk,
  output logic              Busy,
  output logic              FrameDone
);

  localparam int DIV_W = $clog2(DIV);
  // Wide enough for both DATA_W-1 and STOP_BITS-1.
  localparam int CNT_W = $clog2(DATA_W + 2);

  localparam logic [DIV_W-1:0] c_div_last  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] c_div_half  = DIV_W'(DIV / 2);
  localparam logic [CNT_W-1:0] c_data_last = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] c_stop_last = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div,   w_div_nxt;
  logic [CNT_W-1:0]  r_bit,   w_bit_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_par,   w_par_nxt;

  logic r_ready, r_sdout, r_sdclk, r_busy, r_done;

  logic w_accept, w_bit_end, w_frame_end, w_parity;
  logic w_cur_bit_nxt, w_sdout_nxt, w_sdclk_nxt, w_busy_nxt, w_ready_nxt;

  // r_ready holds the "can accept" flag; it is masked by Reset so that the
  // port reads 0 during reset and 1 immediately once reset is released.
  assign Ready     = r_ready & ~Reset;
  assign SDout     = r_sdout;
  assign SDClk     = r_sdclk;
  assign Busy      = r_busy;
  assign FrameDone = r_done;

  assign w_accept    = Valid & Ready;
  assign w_bit_end   = (r_div == c_div_last);
  assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_bit == c_stop_last);
  assign w_parity    = (PARITY_ODD != 0) ? ~^PDin : ^PDin;

  // Next-state, counters and data path.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = '0;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;

    if (r_state != S_IDLE) begin
      w_div_nxt = w_bit_end ? '0 : r_div + DIV_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_START;
          w_bit_nxt   = '0;
          w_shift_nxt = PDin;
          w_par_nxt   = w_parity;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          // Move the next data bit into the sending position.
          w_shift_nxt = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
          if (r_bit == c_data_last) begin
            w_bit_nxt   = '0;
            w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_nxt = r_bit + CNT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_bit_nxt   = '0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_bit == c_stop_last) begin
            w_bit_nxt = '0;
            // Accept in the final stop cycle chains the next frame directly.
            if (w_accept) begin
              w_state_nxt = S_START;
              w_shift_nxt = PDin;
              w_par_nxt   = w_parity;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_bit_nxt = r_bit + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered, so they are derived from the next-state values.
  always_comb begin
    w_cur_bit_nxt = (MSB_FIRST != 0) ? w_shift_nxt[DATA_W-1] : w_shift_nxt[0];
    w_sdout_nxt   = 1'b0;
    case (w_state_nxt)
      S_START:  w_sdout_nxt = 1'b1;
      S_DATA:   w_sdout_nxt = w_cur_bit_nxt;
      S_PARITY: w_sdout_nxt = w_par_nxt;
      default:  w_sdout_nxt = 1'b0;
    endcase
    w_sdclk_nxt = (w_state_nxt != S_IDLE) && (w_div_nxt >= c_div_half);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_ready_nxt = (w_state_nxt == S_IDLE) ||
                  ((w_state_nxt == S_STOP) && (w_div_nxt == c_div_last) &&
                   (w_bit_nxt == c_stop_last));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_ready <= 1'b1;
      r_sdout <= 1'b0;
      r_sdclk <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_ready <= w_ready_nxt;
      r_sdout <= w_sdout_nxt;
      r_sdclk <= w_sdclk_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_frame_end;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx_param
//  Purpose  : Self-checking bench for serial_tx_param. Five instances cover
//             the default configuration, odd parity, LSB-first with two stop
//             bits, a one-bit word with DIV=2, and no parity with DIV=6.
//             Expected line activity is computed from the frame rules.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_tx_param;

  localparam int N = 5;

  int P_DW  [N] = '{8, 8, 8, 1, 8};
  int P_DIV [N] = '{4, 4, 4, 2, 6};
  int P_PE  [N] = '{1, 1, 1, 1, 0};
  int P_PO  [N] = '{0, 1, 0, 0, 0};
  int P_SB  [N] = '{1, 1, 2, 1, 1};
  int P_MSB [N] = '{1, 1, 0, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst, valid, rdy, sd, sck, busy, done;
  logic [7:0]   pdin [N];

  int n_chk = 0;
  int n_err = 0;

  serial_tx_param #(.DATA_W(8), .DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .MSB_FIRST(1)) u0 (
    .Clk(clk), .Reset(rst[0]), .PDin(pdin[0]), .Valid(valid[0]), .Ready(rdy[0]),
    .SDout(sd[0]), .SDClk(sck[0]), .Busy(busy[0]), .FrameDone(done[0]));

  serial_tx_param #(.DATA_W(8), .DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .MSB_FIRST(1)) u1 (
    .Clk(clk), .Reset(rst[1]), .PDin(pdin[1]), .Valid(valid[1]), .Ready(rdy[1]),
    .SDout(sd[1]), .SDClk(sck[1]), .Busy(busy[1]), .FrameDone(done[1]));

  serial_tx_param #(.DATA_W(8), .DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .MSB_FIRST(0)) u2 (
    .Clk(clk), .Reset(rst[2]), .PDin(pdin[2]), .Valid(valid[2]), .Ready(rdy[2]),
    .SDout(sd[2]), .SDClk(sck[2]), .Busy(busy[2]), .FrameDone(done[2]));

  serial_tx_param #(.DATA_W(1), .DIV(2), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .MSB_FIRST(1)) u3 (
    .Clk(clk), .Reset(rst[3]), .PDin(pdin[3][0:0]), .Valid(valid[3]), .Ready(rdy[3]),
    .SDout(sd[3]), .SDClk(sck[3]), .Busy(busy[3]), .FrameDone(done[3]));

  serial_tx_param #(.DATA_W(8), .DIV(6), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .MSB_FIRST(1)) u4 (
    .Clk(clk), .Reset(rst[4]), .PDin(pdin[4]), .Valid(valid[4]), .Ready(rdy[4]),
    .SDout(sd[4]), .SDClk(sck[4]), .Busy(busy[4]), .FrameDone(done[4]));

  // Number of bits in one frame of instance k.
  function automatic int frame_bits(input int k);
    return 1 + P_DW[k] + P_PE[k] + P_SB[k];
  endfunction

  // Level of bit b (0 = start bit) in the frame carrying word w on instance k.
  function automatic logic exp_bit(input int k, input logic [7:0] w, input int b);
    int dw;
    int ones;
    int pos;
    dw   = P_DW[k];
    ones = 0;
    if (b == 0) return 1'b1;
    if (b <= dw) begin
      pos = (P_MSB[k] != 0) ? (dw - b) : (b - 1);
      return w[pos];
    end
    if ((P_PE[k] != 0) && (b == dw + 1)) begin
      for (int j = 0; j < dw; j++) ones += int'(w[j]);
      // Parity bit makes the total count of ones even (or odd).
      return (P_PO[k] != 0) ? logic'((ones + 1) % 2) : logic'(ones % 2);
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input int k, input int cyc, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s inst=%0d cyc=%0d observed=%b expected=%b", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input int k, input int cyc, input logic e_sd, input logic e_sck,
                         input logic e_busy, input logic e_rdy, input logic e_done);
    chk("SDout",     k, cyc, sd[k],   e_sd);
    chk("SDClk",     k, cyc, sck[k],  e_sck);
    chk("Busy",      k, cyc, busy[k], e_busy);
    chk("Ready",     k, cyc, rdy[k],  e_rdy);
    chk("FrameDone", k, cyc, done[k], e_done);
  endtask

  // One idle cycle: line quiet, transmitter ready.
  task automatic idle_step(input int k, input logic e_done);
    @(posedge clk);
    @(negedge clk);
    chk_all(k, -1, 1'b0, 1'b0, 1'b0, 1'b1, e_done);
  endtask

  // Entered at a negedge where instance k is ready. Sends w and checks every
  // cycle of the frame; returns at the negedge of the final stop cycle.
  // hold: keep Valid high with nxt on PDin for the next frame.
  // abort_at: frame cycle at which Reset is pulsed (-1 for none).
  task automatic send(input int k, input logic [7:0] w, input bit hold, input logic [7:0] nxt,
                      input bit prev_done, input int abort_at);
    int total;
    int dv;
    dv    = P_DIV[k];
    total = frame_bits(k) * dv;
    valid[k] = 1'b1;
    pdin[k]  = w;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      pdin[k] = nxt;
    end else begin
      valid[k] = 1'b0;
      pdin[k]  = 8'($urandom);
    end
    for (int i = 0; i < total; i++) begin
      chk_all(k, i, exp_bit(k, w, i / dv), ((i % dv) >= (dv / 2)), 1'b1,
              (i == total - 1), ((i == 0) && prev_done));
      if (i == abort_at) begin
        rst[k] = 1'b1;
        #1;
        chk("ReadyInReset", k, i, rdy[k], 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst[k] = 1'b0;
        #1;
        chk_all(k, i + 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int j = 0; j < total; j++) idle_step(k, 1'b0);
        return;
      end
      if (i < total - 1) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [7:0] w1;
    logic [7:0] w2;
    logic [7:0] dir [N];
    dir   = '{8'hA5, 8'h01, 8'h80, 8'h01, 8'hA5};
    rst   = '1;
    valid = '0;
    for (int k = 0; k < N; k++) pdin[k] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) chk_all(k, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = '0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) chk_all(k, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Single frame, then back-to-back frames with Valid held high.
    send(0, 8'hA5, 1'b0, 8'h00, 1'b0, -1);
    idle_step(0, 1'b1);
    idle_step(0, 1'b0);
    send(0, 8'h3C, 1'b1, 8'hC3, 1'b0, -1);
    send(0, 8'hC3, 1'b0, 8'h00, 1'b1, -1);
    idle_step(0, 1'b1);
    idle_step(0, 1'b0);

    // Directed word per configuration, then random words, some chained.
    for (int k = 0; k < N; k++) begin
      send(k, dir[k], 1'b0, 8'h00, 1'b0, -1);
      idle_step(k, 1'b1);
      idle_step(k, 1'b0);
      for (int r = 0; r < 3; r++) begin
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          send(k, w1, 1'b1, w2, 1'b0, -1);
          send(k, w2, 1'b0, 8'h00, 1'b1, -1);
        end else begin
          send(k, w1, 1'b0, 8'h00, 1'b0, -1);
        end
        idle_step(k, 1'b1);
        idle_step(k, 1'b0);
      end
    end

    // Reset during the 3rd data bit, then a clean frame afterwards.
    send(0, 8'h5A, 1'b0, 8'h00, 1'b0, 3 * P_DIV[0] + 1);
    send(0, 8'hA5, 1'b0, 8'h00, 1'b0, -1);
    idle_step(0, 1'b1);
    idle_step(0, 1'b0);
    send(3, 8'h01, 1'b0, 8'h00, 1'b0, 2 * P_DIV[3]);
    send(3, 8'h00, 1'b0, 8'h00, 1'b0, -1);
    idle_step(3, 1'b1);
    idle_step(3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
